// File: rtl/selector_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// selector_cmd_ctrl : one-at-a-time command sequencer for the 4-cell selector.
// Optional SEL_INIT_EN: fills every cell with INIT_VALUE after reset.
// Revision: 1.0
// ============================================================================
module selector_cmd_ctrl #(
  parameter int                DATA_W     = 8,
  parameter int                ADR_W      = 2,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [1:0]        req_op_i,
  input  logic [ADR_W-1:0]  req_adr_i,
  input  logic [DATA_W-1:0] req_data_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic [1:0]        sel_cmd_o,
  output logic [ADR_W-1:0]  sel_adr_o,
  output logic [DATA_W-1:0] sel_data_o,
  input  logic [DATA_W-1:0] sel_data_i
);

  localparam logic [1:0] OP_NOP     = 2'b00;
  localparam logic [1:0] OP_READ    = 2'b01;
  localparam logic [1:0] OP_WRITE   = 2'b10;
  localparam logic [1:0] OP_DIRECT  = 2'b11;

  localparam logic [1:0] CMD_IDLE   = 2'b00;
  localparam logic [1:0] CMD_READ   = 2'b01;
  localparam logic [1:0] CMD_WRITE  = 2'b10;
  localparam logic [1:0] CMD_DIRECT = 2'b11;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ISSUE    = 3'd1;
  localparam logic [2:0] ST_CAPT     = 3'd2;
  localparam logic [2:0] ST_RESP     = 3'd3;
`ifdef SEL_INIT_EN
  localparam logic [2:0] ST_INIT     = 3'd4;
  localparam logic [2:0] ST_INIT_END = 3'd5;
  localparam logic [2:0] ST_RESET    = ST_INIT;
`else
  localparam logic [2:0] ST_RESET    = ST_IDLE;
`endif

  function automatic logic [1:0] op_to_cmd(input logic [1:0] op);
    logic [1:0] cmd;
    case (op)
      OP_READ:   cmd = CMD_READ;
      OP_WRITE:  cmd = CMD_WRITE;
      OP_DIRECT: cmd = CMD_DIRECT;
      OP_NOP:    cmd = CMD_IDLE;
      default:   cmd = CMD_IDLE;
    endcase
    return cmd;
  endfunction

  logic [2:0]        state_q,     state_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q,  rsp_data_d;
  logic [1:0]        sel_cmd_q,   sel_cmd_d;
  logic [ADR_W-1:0]  sel_adr_q,   sel_adr_d;
  logic [DATA_W-1:0] sel_data_q,  sel_data_d;

`ifdef SEL_INIT_EN
  logic [ADR_W-1:0]  init_cnt_q,  init_cnt_d;
`else
  logic              unused_init;
  assign unused_init = ^INIT_VALUE;
`endif

  always_comb begin
    state_d     = state_q;
    req_ready_d = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    sel_cmd_d   = CMD_IDLE;
    sel_adr_d   = sel_adr_q;
    sel_data_d  = sel_data_q;
`ifdef SEL_INIT_EN
    init_cnt_d  = init_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // req_ready_q gates the handshake, so the first post-reset cycle never accepts
        req_ready_d = 1'b1;
        if (req_valid_i && req_ready_q) begin
          sel_cmd_d   = op_to_cmd(req_op_i);
          sel_adr_d   = req_adr_i;
          sel_data_d  = req_data_i;
          req_ready_d = 1'b0;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_CAPT;
      end
      ST_CAPT: begin
        rsp_data_d  = sel_data_i;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
`ifdef SEL_INIT_EN
      ST_INIT: begin
        sel_cmd_d  = CMD_WRITE;
        sel_adr_d  = init_cnt_q;
        sel_data_d = INIT_VALUE;
        init_cnt_d = init_cnt_q + ADR_W'(1);
        if (init_cnt_q == {ADR_W{1'b1}}) begin
          state_d = ST_INIT_END;
        end
      end
      ST_INIT_END: begin
        // selector sees one idle command after the last fill write
        req_ready_d = 1'b1;
        state_d     = ST_IDLE;
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_RESET;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      sel_cmd_q   <= CMD_IDLE;
      sel_adr_q   <= '0;
      sel_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      sel_cmd_q   <= sel_cmd_d;
      sel_adr_q   <= sel_adr_d;
      sel_data_q  <= sel_data_d;
    end
  end

`ifdef SEL_INIT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      init_cnt_q <= '0;
    end else begin
      init_cnt_q <= init_cnt_d;
    end
  end
`endif

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign sel_cmd_o   = sel_cmd_q;
  assign sel_adr_o   = sel_adr_q;
  assign sel_data_o  = sel_data_q;

endmodule
`default_nettype wire

// File: tb/tb_selector_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// tb_selector_cmd_ctrl : directed and randomized checks of selector_cmd_ctrl
// against a behavioural selector and a transaction-level reference model.
// Revision: 1.0
// ============================================================================
module tb_selector_cmd_ctrl;

  localparam int                DATA_W = 8;
  localparam int                ADR_W  = 2;
  localparam int                NCELL  = 1 << ADR_W;
  localparam logic [DATA_W-1:0] INIT_V = 8'h5A;

  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_READ   = 2'b01;
  localparam logic [1:0] OP_WRITE  = 2'b10;
  localparam logic [1:0] OP_DIRECT = 2'b11;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [1:0]        req_op = 2'b00;
  logic [ADR_W-1:0]  req_adr = '0;
  logic [DATA_W-1:0] req_data = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DATA_W-1:0] rsp_data;
  logic [1:0]        sel_cmd;
  logic [ADR_W-1:0]  sel_adr;
  logic [DATA_W-1:0] sel_wdata;
  logic [DATA_W-1:0] sel_q;

  always #5 clk = ~clk;

  selector_cmd_ctrl #(
    .DATA_W     (DATA_W),
    .ADR_W      (ADR_W),
    .INIT_VALUE (INIT_V)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_op_i    (req_op),
    .req_adr_i   (req_adr),
    .req_data_i  (req_data),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data),
    .sel_cmd_o   (sel_cmd),
    .sel_adr_o   (sel_adr),
    .sel_data_o  (sel_wdata),
    .sel_data_i  (sel_q)
  );

  // Behavioural 4-cell selector: {read, write} command, registered output.
  logic [DATA_W-1:0] cells [NCELL];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q <= '0;
    end else begin
      case (sel_cmd)
        2'b01:   sel_q <= cells[sel_adr];
        2'b10:   begin cells[sel_adr] <= sel_wdata; sel_q <= '0; end
        2'b11:   sel_q <= sel_wdata;
        default: sel_q <= '0;
      endcase
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Transaction-level reference state
  logic [DATA_W-1:0] ref_mem [NCELL];
  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] got_q [$];
  int   cyc = 0;
  int   outstanding = 0;
  int   acc_cyc = 0;
  int   last_acc = 0;
  bit   last_acc_ok = 1'b0;
  bit   tput_chk = 1'b0;
  bit   rand_bp = 1'b0;
  bit   last_hs_req = 1'b0;

  function automatic logic [1:0] cmd_for(input logic [1:0] op);
    case (op)
      OP_READ:   return 2'b01;
      OP_WRITE:  return 2'b10;
      OP_DIRECT: return 2'b11;
      default:   return 2'b00;
    endcase
  endfunction

  // One clock: note handshakes before the edge, then check after it.
  task automatic step();
    logic              hs_req, hs_rsp, prev_valid, exp_valid;
    logic [1:0]        op, exp_cmd;
    logic [ADR_W-1:0]  adr;
    logic [DATA_W-1:0] dat, rdat, exp_rsp;
    if (rand_bp) rsp_ready = ($urandom_range(0, 3) != 0);
    hs_req     = req_valid && req_ready;
    hs_rsp     = rsp_valid && rsp_ready;
    op         = req_op;
    adr        = req_adr;
    dat        = req_data;
    rdat       = rsp_data;
    prev_valid = rsp_valid;
    @(posedge clk);
    #1;
    cyc++;
    last_hs_req = hs_req;
    exp_cmd = 2'b00;
    if (hs_req) begin
      case (op)
        OP_READ:   exp_rsp = ref_mem[adr];
        OP_WRITE:  begin ref_mem[adr] = dat; exp_rsp = '0; end
        OP_DIRECT: exp_rsp = dat;
        default:   exp_rsp = '0;
      endcase
      exp_q.push_back(exp_rsp);
      outstanding++;
      if (tput_chk && last_acc_ok) check_val("throughput", cyc - last_acc, 4);
      last_acc    = cyc;
      last_acc_ok = 1'b1;
      acc_cyc     = cyc;
      exp_cmd     = cmd_for(op);
      check_val("sel_adr", {30'd0, sel_adr}, {30'd0, adr});
      check_val("sel_data", {24'd0, sel_wdata}, {24'd0, dat});
    end
    if (hs_rsp) begin
      if (exp_q.size() == 0) begin
        check_val("rsp_unexpected", 1, 0);
      end else begin
        check_val("rsp_hs_data", {24'd0, rdat}, {24'd0, exp_q.pop_front()});
      end
      got_q.push_back(rdat);
      if (outstanding > 0) outstanding--;
    end
    check_val("sel_cmd", {30'd0, sel_cmd}, {30'd0, exp_cmd});
    check_val("req_ready", {31'd0, req_ready}, {31'd0, (outstanding == 0)});
    exp_valid = (outstanding > 0) && ((cyc - acc_cyc) >= 2);
    check_val("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_valid});
    // counting the accept edge, the response appears on the third edge
    if (rsp_valid && !prev_valid) check_val("rsp_latency_edges", cyc - acc_cyc + 1, 3);
    if (rsp_valid && exp_q.size() > 0) check_val("rsp_data", {24'd0, rsp_data}, {24'd0, exp_q[0]});
  endtask

  task automatic send(input logic [1:0] op, input logic [ADR_W-1:0] adr, input logic [DATA_W-1:0] dat);
    int n = 0;
    req_valid = 1'b1;
    req_op    = op;
    req_adr   = adr;
    req_data  = dat;
    do begin
      step();
      n++;
    end while (!last_hs_req && n < 40);
    if (!last_hs_req) check_val("accept_timeout", n, 0);
    req_valid = 1'b0;
    req_op    = 2'($urandom);
    req_adr   = ADR_W'($urandom);
    req_data  = DATA_W'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (outstanding > 0 && n < 60) begin
      step();
      n++;
    end
    if (outstanding > 0) check_val("drain_timeout", outstanding, 0);
  endtask

  task automatic check_got(input string tag, input logic [DATA_W-1:0] exp []);
    check_val({tag, "_count"}, got_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got_q.size(); i++) begin
      check_val(tag, {24'd0, got_q[i]}, {24'd0, exp[i]});
    end
    got_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_val("rst_req_ready", {31'd0, req_ready}, 0);
    check_val("rst_rsp_valid", {31'd0, rsp_valid}, 0);
    check_val("rst_rsp_data", {24'd0, rsp_data}, 0);
    check_val("rst_sel_cmd", {30'd0, sel_cmd}, 0);
    check_val("rst_sel_adr", {30'd0, sel_adr}, 0);
    check_val("rst_sel_data", {24'd0, sel_wdata}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    got_q.delete();
    outstanding = 0;
    last_acc_ok = 1'b0;
    check_val("post_rst_ready", {31'd0, req_ready}, 0);
`ifdef SEL_INIT_EN
    for (int i = 0; i < NCELL; i++) begin
      @(posedge clk);
      #1;
      check_val("init_cmd", {30'd0, sel_cmd}, 2);
      check_val("init_adr", {30'd0, sel_adr}, i);
      check_val("init_data", {24'd0, sel_wdata}, {24'd0, INIT_V});
      check_val("init_ready", {31'd0, req_ready}, 0);
      check_val("init_rsp_valid", {31'd0, rsp_valid}, 0);
    end
    @(posedge clk);
    #1;
    check_val("init_end_cmd", {30'd0, sel_cmd}, 0);
    check_val("init_end_ready", {31'd0, req_ready}, 1);
    for (int i = 0; i < NCELL; i++) ref_mem[i] = INIT_V;
`endif
  endtask

  initial begin
    logic [DATA_W-1:0] hold;
    int n;
    for (int i = 0; i < NCELL; i++) ref_mem[i] = '0;
    #3;
    do_reset();
    rsp_ready = 1'b1;

`ifdef SEL_INIT_EN
    for (int i = 0; i < NCELL; i++) send(OP_READ, ADR_W'(i), 8'h00);
    drain();
    check_got("init_read", '{INIT_V, INIT_V, INIT_V, INIT_V});
`endif

    // Reset while the controller sits in CAPT: the response must vanish
    send(OP_READ, 2'd1, 8'h00);
    step();
    do_reset();
    repeat (4) step();
    check_val("no_rsp_after_rst", got_q.size(), 0);

    // Back-to-back writes then reads in reverse order
    last_acc_ok = 1'b0;
    tput_chk    = 1'b1;
    for (int i = 0; i < NCELL; i++) send(OP_WRITE, ADR_W'(i), DATA_W'(8'h10 + i));
    for (int i = NCELL - 1; i >= 0; i--) send(OP_READ, ADR_W'(i), 8'h00);
    drain();
    tput_chk = 1'b0;
    check_got("ordering", '{8'h00, 8'h00, 8'h00, 8'h00, 8'h13, 8'h12, 8'h11, 8'h10});

    send(OP_WRITE, 2'd2, 8'hA5);
    send(OP_READ, 2'd2, 8'h00);
    drain();
    check_got("write_read", '{8'h00, 8'hA5});

    send(OP_DIRECT, 2'd1, 8'h3C);
    send(OP_NOP, 2'd3, 8'hFF);
    drain();
    check_got("direct_nop", '{8'h3C, 8'h00});

    // Backpressure: response held, a waiting request stays unaccepted
    rsp_ready = 1'b0;
    send(OP_READ, 2'd2, 8'h00);
    n = 0;
    while (!rsp_valid && n < 10) begin step(); n++; end
    check_val("bp_rsp_seen", {31'd0, rsp_valid}, 1);
    hold      = rsp_data;
    req_valid = 1'b1;
    req_op    = OP_DIRECT;
    req_adr   = 2'd0;
    req_data  = 8'h77;
    for (int i = 0; i < 5; i++) begin
      step();
      check_val("bp_hold_data", {24'd0, rsp_data}, {24'd0, hold});
      check_val("bp_no_accept", {31'd0, last_hs_req}, 0);
    end
    rsp_ready = 1'b1;
    step();
    check_val("bp_no_accept_hs", {31'd0, last_hs_req}, 0);
    step();
    check_val("bp_accept_after", {31'd0, last_hs_req}, 1);
    req_valid = 1'b0;
    drain();
    check_got("backpressure", '{8'hA5, 8'h77});

    // Randomized traffic with random response backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 80; i++) begin
      send(2'($urandom), ADR_W'($urandom), DATA_W'($urandom));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) step();
    end
    drain();
    rand_bp   = 1'b0;
    rsp_ready = 1'b1;
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
